// File: rtl/blk_com_fifo_256x32_rd_burst.sv
// Read-side burst controller for the 256x32 common FIFO.
// Drains the FIFO read port into fixed-length sop/eop-framed bursts on a
// valid/ready stream. A burst starts when BURST_LEN words are buffered, or
// when TIMEOUT_CYC non-empty idle cycles pass with residual data. A 2-entry
// output buffer hides the FIFO's 1-cycle read latency.
//
// Stream handshake: a beat transfers on a rising clk edge where
// o_valid & i_ready. Once o_valid is high, it holds with o_data/o_sop/o_eop
// stable until that transfer. o_valid comes only from registered buffer
// occupancy. i_ready feeds fifo_rd_en combinationally, so a slot freed this
// cycle can be refilled at once.
module blk_com_fifo_256x32_rd_burst #(
  parameter int BURST_LEN   = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fifo_dout,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  input  logic [7:0]  fifo_data_count,
  output logic        fifo_rd_en,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_sop,
  output logic        o_eop,
  input  logic        i_ready,
  output logic        o_busy
);

  localparam logic [8:0]  BL      = 9'(BURST_LEN);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t      state;
  logic [15:0] timer;
  logic [8:0]  len;
  logic [8:0]  issued;
  logic [8:0]  wr_idx;
  logic        inflight;
  logic [33:0] buf_mem [2];   // {sop, eop, data}
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  buf_cnt;
  logic [8:0]  occ;
  logic        pop;
  logic [2:0]  fill;
  logic [33:0] head;

  // A full FIFO reports count 0, so the full flag supplies the 256.
  assign occ  = fifo_full ? 9'd256 : {1'b0, fifo_data_count};
  assign head = buf_mem[rd_ptr];

  assign o_valid = (buf_cnt != 2'd0);
  assign o_data  = head[31:0];
  assign o_sop   = o_valid & head[33];
  assign o_eop   = o_valid & head[32];
  assign o_busy  = (state != IDLE);
  assign pop     = o_valid & i_ready;

  // Slots committed after this cycle: buffered plus in flight minus leaving.
  assign fill = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};

  assign fifo_rd_en = (state == BURST) && (issued < len) && !fifo_empty
                      && (fill < 3'd2);

  // Burst sequencing: idle timer, trigger selection, read issue count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      timer  <= 16'd0;
      len    <= 9'd0;
      issued <= 9'd0;
    end else begin
      case (state)
        IDLE: begin
          if (occ >= BL) begin
            state  <= BURST;
            len    <= BL;
            issued <= 9'd0;
            timer  <= 16'd0;
          end else if (!fifo_empty && (timer == TO_LAST)) begin
            state  <= BURST;
            len    <= (occ == 9'd0) ? 9'd1 : occ;
            issued <= 9'd0;
            timer  <= 16'd0;
          end else if (fifo_empty) begin
            timer <= 16'd0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        BURST: begin
          if (fifo_rd_en) begin
            issued <= issued + 9'd1;
            if ((issued + 9'd1) == len) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && o_eop) begin
            state <= IDLE;
            timer <= 16'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-latency tracking and 2-entry output buffer with sop/eop tagging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight   <= 1'b0;
      buf_mem[0] <= 34'd0;
      buf_mem[1] <= 34'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      buf_cnt    <= 2'd0;
      wr_idx     <= 9'd0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) begin
        buf_mem[wr_ptr] <= {(wr_idx == 9'd0), (wr_idx == (len - 9'd1)), fifo_dout};
        wr_ptr          <= ~wr_ptr;
      end
      if (state == IDLE)  wr_idx <= 9'd0;
      else if (inflight)  wr_idx <= wr_idx + 9'd1;
      if (pop) rd_ptr <= ~rd_ptr;
      buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_blk_com_fifo_256x32_rd_burst.sv
// Bench for blk_com_fifo_256x32_rd_burst: a behavioural FIFO feeds the
// default instance; a second instance with BURST_LEN=1 is driven by hand.
module tb_blk_com_fifo_256x32_rd_burst;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance (16 / 64)
  logic [31:0] fifo_dout;
  logic        fifo_empty, fifo_full, fifo_rd_en;
  logic [7:0]  fifo_data_count;
  logic [31:0] o_data;
  logic        o_valid, o_sop, o_eop, i_ready, o_busy;

  // BURST_LEN=1 instance
  logic [31:0] fifo_dout1;
  logic        fifo_empty1, fifo_full1, fifo_rd_en1;
  logic [7:0]  fifo_data_count1;
  logic [31:0] o_data1;
  logic        o_valid1, o_sop1, o_eop1, i_ready1, o_busy1;

  blk_com_fifo_256x32_rd_burst #(.BURST_LEN(16), .TIMEOUT_CYC(64)) u_dut (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_data_count(fifo_data_count),
    .fifo_rd_en(fifo_rd_en), .o_data(o_data), .o_valid(o_valid),
    .o_sop(o_sop), .o_eop(o_eop), .i_ready(i_ready), .o_busy(o_busy)
  );

  blk_com_fifo_256x32_rd_burst #(.BURST_LEN(1), .TIMEOUT_CYC(64)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout1), .fifo_empty(fifo_empty1),
    .fifo_full(fifo_full1), .fifo_data_count(fifo_data_count1),
    .fifo_rd_en(fifo_rd_en1), .o_data(o_data1), .o_valid(o_valid1),
    .o_sop(o_sop1), .o_eop(o_eop1), .i_ready(i_ready1), .o_busy(o_busy1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [31:0] fq[$];
  logic        rd_pend = 1'b0;
  int          underflows = 0;

  function automatic void update_flags();
    fifo_empty      = (fq.size() == 0);
    fifo_full       = (fq.size() >= 256);
    fifo_data_count = 8'(fq.size());
  endfunction

  task automatic push_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) fq.push_back(base + 32'(i));
    update_flags();
  endtask

  always @(negedge clk) rd_pend = fifo_rd_en;

  always @(posedge clk) begin : fifo_model
    logic take;
    take = rd_pend && !rst;
    #1;
    if (take) begin
      if (fq.size() == 0) underflows++;
      else fifo_dout = fq.pop_front();
      update_flags();
    end
  end

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];
  int reads_cnt = 0, acc_cnt = 0, max_ahead = 0;

  task automatic push_exp(input int len, input logic [31:0] base);
    logic s, e;
    for (int i = 0; i < len; i++) begin
      s = (i == 0);
      e = (i == len - 1);
      exp_q.push_back({s, e, base + 32'(i)});
    end
  endtask

  always @(negedge clk) begin : monitor
    int ahead;
    logic [33:0] exp;
    if (rst) begin
      reads_cnt = 0;
      acc_cnt   = 0;
    end else begin
      ahead = reads_cnt - acc_cnt - int'(o_valid && i_ready) + int'(fifo_rd_en);
      if (ahead > max_ahead) max_ahead = ahead;
      if (fifo_rd_en) reads_cnt++;
      if (o_valid && i_ready) begin
        acc_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got=%0h sop=%0b eop=%0b", o_data, o_sop, o_eop);
        end else begin
          exp = exp_q.pop_front();
          if ({o_sop, o_eop, o_data} !== exp) begin
            failures++;
            $display("FAIL beat got={sop,eop,data}=%0h exp=%0h", {o_sop, o_eop, o_data}, exp);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic ready_val(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    return ((cyc % 4) == 0) || ((cyc % 4) == 3);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    fq.delete();
    exp_q.delete();
    update_flags();
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_burst(input int mode, output int first_rd, output int first_v,
                            output int n_rd, output int last_rd, output bit done);
    int cyc;
    first_rd = -1; first_v = -1; n_rd = 0; last_rd = -1; done = 1'b0; cyc = 0;
    i_ready = ready_val(mode, 0);
    while (!done && cyc < 400) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        n_rd++;
      end
      if (o_valid && first_v < 0) first_v = cyc;
      @(posedge clk);
      #1;
      cyc++;
      i_ready = ready_val(mode, cyc);
      if (exp_q.size() == 0 && !o_busy) done = 1'b1;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          fresh;
    int          n_words;
    logic [31:0] base;
    int          ready_mode;
    int          exp_first_rd;
    int          exp_first_valid;
    int          exp_len;
    int          exp_rd_span;
    int          exp_left;
    logic [31:0] exp_base;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int idx, input vec_t v);
    int first_rd, first_v, n_rd, last_rd;
    bit done;
    if (v.fresh) begin
      do_reset();
      push_words(v.n_words, v.base);
    end
    push_exp(v.exp_len, v.exp_base);
    wait_burst(v.ready_mode, first_rd, first_v, n_rd, last_rd, done);
    check($sformatf("v%0d_done", idx), 64'(done), 64'd1);
    check($sformatf("v%0d_first_rd", idx), 64'(first_rd), 64'(v.exp_first_rd));
    check($sformatf("v%0d_first_valid", idx), 64'(first_v), 64'(v.exp_first_valid));
    check($sformatf("v%0d_n_rd", idx), 64'(n_rd), 64'(v.exp_len));
    if (v.exp_rd_span >= 0)
      check($sformatf("v%0d_rd_span", idx), 64'(last_rd - first_rd + 1), 64'(v.exp_rd_span));
    check($sformatf("v%0d_left", idx), 64'(fq.size()), 64'(v.exp_left));
  endtask

  // ---------------- main ----------------
  initial begin : main
    int first_rd, first_v, n_rd, last_rd, beats, guard;
    bit done;

    fifo_dout = 32'd0;
    fifo_dout1 = 32'd0; fifo_empty1 = 1'b1; fifo_full1 = 1'b0;
    fifo_data_count1 = 8'd0; i_ready1 = 1'b1;

    //           fresh n    base       rdy rd  val len span left base
    vecs[0] = '{1'b1, 16,  32'h100, 0,  1,  3,  16, 16,  0,   32'h100};
    vecs[1] = '{1'b1, 5,   32'h200, 0,  64, 66, 5,  5,   0,   32'h200};
    vecs[2] = '{1'b1, 40,  32'h300, 1,  1,  3,  16, -1,  24,  32'h300};
    vecs[3] = '{1'b0, 0,   32'h000, 1,  1,  3,  16, -1,  8,   32'h310};
    vecs[4] = '{1'b1, 256, 32'h400, 0,  1,  3,  16, 16,  240, 32'h400};

    do_reset();
    check("reset_outputs", {fifo_rd_en, o_valid, o_sop, o_eop, o_busy, o_data}, 64'd0);
    check("reset_outputs_bl1", {fifo_rd_en1, o_valid1, o_sop1, o_eop1, o_busy1, o_data1}, 64'd0);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Reset mid-burst after the 7th accepted beat.
    do_reset();
    push_words(16, 32'h600);
    push_exp(16, 32'h600);
    i_ready = 1'b1;
    beats = 0; guard = 0;
    while (beats < 7 && guard < 100) begin
      @(negedge clk);
      if (o_valid && i_ready) beats++;
      guard++;
    end
    check("rst_mid_beats", 64'(beats), 64'd7);
    #1 rst = 1'b1;
    #1 check("rst_mid_outputs", {fifo_rd_en, o_valid, o_sop, o_eop, o_busy, o_data}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_left", 64'(fq.size()), 64'd8);
    push_exp(8, 32'h608);
    wait_burst(0, first_rd, first_v, n_rd, last_rd, done);
    check("rst_mid_done", 64'(done), 64'd1);
    check("rst_mid_first_rd", 64'(first_rd), 64'd64);
    check("rst_mid_n_rd", 64'(n_rd), 64'd8);
    check("rst_mid_empty", 64'(fq.size()), 64'd0);

    // BURST_LEN=1: single word, sop and eop together.
    fifo_empty1 = 1'b0; fifo_data_count1 = 8'd1;
    @(negedge clk);
    check("bl1_c0_rd", 64'(fifo_rd_en1), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bl1_c1_rd_busy", {fifo_rd_en1, o_busy1}, 64'b11);
    @(posedge clk); #1;
    fifo_empty1 = 1'b1; fifo_data_count1 = 8'd0; fifo_dout1 = 32'hDEADBEEF;
    @(negedge clk);
    check("bl1_c2_rd", {fifo_rd_en1, o_valid1}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bl1_c3_beat", {o_valid1, o_sop1, o_eop1, o_data1}, {3'b111, 32'hDEADBEEF});
    @(posedge clk); #1;
    @(negedge clk);
    check("bl1_c4_idle", {o_valid1, o_busy1, fifo_rd_en1}, 64'd0);

    check("max_read_ahead", 64'(max_ahead), 64'd2);
    check("underflows", 64'(underflows), 64'd0);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
